// File: rtl/pu_max_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pu_max_collector_pkg
// Description : Shared widths and FSM state encoding for the PU max collector.
// Revision    : 1.0 - initial release
// ============================================================================
package pu_max_collector_pkg;

    // Widths shared with the 4-input processing unit.
    localparam int PU_DATA_W = 12;
    localparam int PU_IN_W   = 5;
    localparam int PU_NUM_IN = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EVAL    = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pu_relu_sat.sv
`default_nettype none
// ============================================================================
// Module      : pu_relu_sat
// Description : ReLU, right shift and unsigned saturation of one PU sum.
// Revision    : 1.0 - initial release
// ============================================================================
module pu_relu_sat
    import pu_max_collector_pkg::*;
#(
    parameter int DATA_W = PU_DATA_W,
    parameter int OUT_W  = PU_IN_W,
    parameter int SHIFT  = 0
) (
    input  logic [DATA_W-1:0] i_data,
    output logic [OUT_W-1:0]  o_q
);

    localparam logic [DATA_W-1:0] c_max = DATA_W'((1 << OUT_W) - 1);

    logic [DATA_W-1:0] w_shift;

    // Negative values are zeroed first, so a logical shift equals the arithmetic one.
    assign w_shift = i_data >> SHIFT;

    always_comb begin
        o_q = '0;
        if (!i_data[DATA_W-1]) begin
            o_q = (w_shift > c_max) ? c_max[OUT_W-1:0] : w_shift[OUT_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/pu_max_collector.sv
`default_nettype none
// ============================================================================
// Module      : pu_max_collector
// Description : Collects PU sums, quantises them as feedback and iterates
//               until a single non-zero winner remains or the limit is hit.
// Revision    : 1.0 - initial release
// ============================================================================
module pu_max_collector
    import pu_max_collector_pkg::*;
#(
    parameter int NUM_IN    = PU_NUM_IN,
    parameter int DATA_W    = PU_DATA_W,
    parameter int OUT_W     = PU_IN_W,
    parameter int SHIFT     = 0,
    parameter int MAX_ITER  = 15,
    localparam int ITER_W   = $clog2(MAX_ITER + 1),
    localparam int IDX_W    = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    in_ready,
    output logic [NUM_IN*OUT_W-1:0] fb_data,
    output logic                    fb_valid,
    output logic                    done,
    output logic                    no_winner,
    output logic [IDX_W-1:0]        winner_idx,
    output logic [OUT_W-1:0]        winner_val,
    output logic [ITER_W-1:0]       iter_count
);

    localparam int c_nz_w = $clog2(NUM_IN + 1);

    state_t                  r_state;
    logic [IDX_W-1:0]        r_cnt;
    logic [NUM_IN*OUT_W-1:0] r_vec;

    logic [OUT_W-1:0]        w_q;
    logic                    w_xfer;
    logic [c_nz_w-1:0]       w_nz;
    logic [IDX_W-1:0]        w_best_idx;
    logic [OUT_W-1:0]        w_best_val;
    logic                    w_finish;

    pu_relu_sat #(
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W),
        .SHIFT  (SHIFT)
    ) u_relu_sat (
        .i_data (in_data),
        .o_q    (w_q)
    );

    assign w_xfer = in_valid & in_ready;

    // Strict comparison keeps the lowest index on ties; an all-zero vector yields 0/0.
    always_comb begin
        w_nz       = '0;
        w_best_idx = '0;
        w_best_val = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (r_vec[k*OUT_W +: OUT_W] != '0) begin
                w_nz = w_nz + 1'b1;
            end
            if (r_vec[k*OUT_W +: OUT_W] > w_best_val) begin
                w_best_val = r_vec[k*OUT_W +: OUT_W];
                w_best_idx = IDX_W'(k);
            end
        end
    end

    assign w_finish = (w_nz <= c_nz_w'(1)) || (iter_count == ITER_W'(MAX_ITER - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_vec      <= '0;
            in_ready   <= 1'b0;
            fb_data    <= '0;
            fb_valid   <= 1'b0;
            done       <= 1'b0;
            no_winner  <= 1'b0;
            winner_idx <= '0;
            winner_val <= '0;
            iter_count <= '0;
        end else begin
            fb_valid <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state    <= COLLECT;
                        in_ready   <= 1'b1;
                        r_cnt      <= '0;
                        iter_count <= '0;
                        done       <= 1'b0;
                        no_winner  <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (w_xfer) begin
                        for (int k = 0; k < NUM_IN; k++) begin
                            if (r_cnt == IDX_W'(k)) begin
                                r_vec[k*OUT_W +: OUT_W] <= w_q;
                            end
                        end
                        if (r_cnt == IDX_W'(NUM_IN - 1)) begin
                            r_cnt    <= '0;
                            in_ready <= 1'b0;
                            r_state  <= EVAL;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                EVAL: begin
                    fb_data <= r_vec;
                    if (iter_count != ITER_W'(MAX_ITER)) begin
                        iter_count <= iter_count + 1'b1;
                    end
                    if (w_finish) begin
                        r_state    <= DONE;
                        done       <= 1'b1;
                        no_winner  <= (w_nz == '0);
                        winner_idx <= w_best_idx;
                        winner_val <= w_best_val;
                    end else begin
                        r_state  <= COLLECT;
                        in_ready <= 1'b1;
                        fb_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
